qspi_rom_reader: RTL and testbench

Quad-SPI flash read engine that fetches cartridge ROM image data from the external QSPI flash and delivers it as a stream of 16-bit words to the cart-side logic. It sits between the `top` cart logic, which issues ROM fetches on behalf of N64 PI bus reads, and the QSPI flash pins (`qspi_clk`, `qspi_cs`, `qspi_dq`). It issues Fast Read Quad I/O (0xEB) transactions, generates SCLK from the system clock and pauses SCLK when the consumer applies backpressure.

---
 rtl/qspi_pkg.sv | 13 +
 rtl/qspi_sclk_gen.sv | 21 ++
 rtl/qspi_rom_reader.sv | 182 ++++++++++++++++++
 tb/tb_qspi_rom_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI ROM reader: FSM states, flash opcode and header lengths.
package qspi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_GAP
  } state_t;

  localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;
  localparam logic [7:0] MODE_BYTE        = 8'h00;

  localparam int CMD_CLKS  = 8;
  localparam int ADDR_CLKS = 6;
  localparam int MODE_CLKS = 2;
endpackage

// File: rtl/qspi_sclk_gen.sv
// SCLK phase generator: 2-cycle SCLK period (low, high), parked low while idle or paused.
module qspi_sclk_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic hold,
  output logic sclk,
  output logic shift_stb
);
  logic phase;

  // Edge ending the high phase: dq_i is sampled and the next period's outputs launch.
  assign shift_stb = active && phase;
  assign sclk      = phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              phase <= 1'b0;
    else if (!active)        phase <= 1'b0;
    else if (phase || !hold) phase <= !phase;
  end
endmodule

// File: rtl/qspi_rom_reader.sv
// Quad-SPI (0xEB) ROM fetch engine streaming 16-bit words with backpressure.
// Define QSPI_ROM_BYTESWAP_EN to swap the two bytes of every delivered word.
module qspi_rom_reader
  import qspi_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CLKS   = 4,
  parameter int CS_HIGH_CLKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [15:0]       rd_data,
  output logic              rd_last,
  output logic              qspi_clk,
  output logic              qspi_cs_n,
  output logic [3:0]        qspi_dq_o,
  output logic [3:0]        qspi_dq_oe,
  input  logic [3:0]        qspi_dq_i
);
  state_t            state, state_n, hdr_next;
  logic [7:0]        cnt, cnt_n, hdr_last;
  logic [8:0]        left, left_n;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       addr24;
  logic [11:0]       sr;
  logic [15:0]       raw_word, fmt_word, pend_data;
  logic              pend_vld, pend_last, ready_q;
  logic              active, shift_stb, word_done, can_load, accept;
  logic [3:0]        dq_o_n, dq_oe_n;
  logic [4:0]        sh;

  assign req_ready = ready_q;
  assign accept    = req_valid && ready_q && (state == ST_IDLE);
  assign active    = (state != ST_IDLE) && (state != ST_GAP);
  assign word_done = shift_stb && (state == ST_DATA) && (cnt[1:0] == 2'd3);
  assign can_load  = !rd_valid || rd_ready;
  assign addr24    = 24'(addr_q);
  assign raw_word  = {sr, qspi_dq_i};
`ifdef QSPI_ROM_BYTESWAP_EN
  assign fmt_word  = {raw_word[7:0], raw_word[15:8]};
`else
  assign fmt_word  = raw_word;
`endif

  qspi_sclk_gen u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (active),
    .hold     (pend_vld),
    .sclk     (qspi_clk),
    .shift_stb(shift_stb)
  );

  always_comb begin
    hdr_last = 8'd0;
    hdr_next = ST_IDLE;
    case (state)
      ST_CMD:   begin hdr_last = 8'(CMD_CLKS - 1);   hdr_next = ST_ADDR;  end
      ST_ADDR:  begin hdr_last = 8'(ADDR_CLKS - 1);  hdr_next = ST_MODE;  end
      ST_MODE:  begin hdr_last = 8'(MODE_CLKS - 1);  hdr_next = ST_DUMMY; end
      ST_DUMMY: begin hdr_last = 8'(DUMMY_CLKS - 1); hdr_next = ST_DATA;  end
      default:  ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    left_n  = left;
    case (state)
      ST_IDLE: if (accept) begin
        state_n = ST_CMD;
        cnt_n   = 8'd0;
        left_n  = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
      end
      ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY: if (shift_stb) begin
        if (cnt == hdr_last) begin
          state_n = hdr_next;
          cnt_n   = 8'd0;
        end else cnt_n = cnt + 8'd1;
      end
      ST_DATA: if (shift_stb) begin
        if (cnt[1:0] == 2'd3) begin
          cnt_n = 8'd0;
          if (left == 9'd1) state_n = ST_GAP;
          else              left_n  = left - 9'd1;
        end else cnt_n = cnt + 8'd1;
      end
      ST_GAP: begin
        // A final word still waiting for the output register keeps us out of IDLE.
        if (cnt >= 8'(CS_HIGH_CLKS - 1)) begin
          if (!pend_vld) state_n = ST_IDLE;
        end else cnt_n = cnt + 8'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pin values for the period that starts after this edge.
  always_comb begin
    dq_o_n  = 4'h0;
    dq_oe_n = 4'h0;
    sh      = 5'd20 - {cnt_n[2:0], 2'b00};
    case (state_n)
      ST_CMD: begin
        dq_o_n  = {3'b000, CMD_QUAD_IO_READ[3'd7 - cnt_n[2:0]]};
        dq_oe_n = 4'b0001;
      end
      ST_ADDR: begin
        dq_o_n  = 4'(addr24 >> sh);
        dq_oe_n = 4'b1111;
      end
      ST_MODE: begin
        dq_o_n  = cnt_n[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        dq_oe_n = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      left       <= 9'd0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      qspi_cs_n  <= 1'b1;
      qspi_dq_o  <= 4'h0;
      qspi_dq_oe <= 4'h0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      left       <= left_n;
      ready_q    <= (state_n == ST_IDLE);
      qspi_cs_n  <= (state_n == ST_IDLE) || (state_n == ST_GAP);
      qspi_dq_o  <= dq_o_n;
      qspi_dq_oe <= dq_oe_n;
      if (accept) addr_q <= req_addr & ~(ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= 12'h0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= 16'h0;
      pend_vld  <= 1'b0;
      pend_last <= 1'b0;
      pend_data <= 16'h0;
    end else begin
      if (shift_stb && state == ST_DATA) sr <= {sr[7:0], qspi_dq_i};
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
      if (word_done) begin
        if (can_load) begin
          rd_valid <= 1'b1;
          rd_data  <= fmt_word;
          rd_last  <= (left == 9'd1);
        end else begin
          pend_vld  <= 1'b1;
          pend_data <= fmt_word;
          pend_last <= (left == 9'd1);
        end
      end else if (pend_vld && can_load) begin
        rd_valid <= 1'b1;
        rd_data  <= pend_data;
        rd_last  <= pend_last;
        pend_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_qspi_rom_reader.sv
// Directed bench for qspi_rom_reader with a behavioural quad-I/O flash model.
module tb_qspi_rom_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'h0;
  logic [7:0]  req_len = 8'h0;
  logic        rd_valid, rd_last;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        qspi_clk, qspi_cs_n;
  logic [3:0]  qspi_dq_o, qspi_dq_oe;
  logic [3:0]  qspi_dq_i = 4'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qspi_rom_reader #(.ADDR_W(24), .DUMMY_CLKS(4), .CS_HIGH_CLKS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .qspi_clk(qspi_clk), .qspi_cs_n(qspi_cs_n),
    .qspi_dq_o(qspi_dq_o), .qspi_dq_oe(qspi_dq_oe), .qspi_dq_i(qspi_dq_i)
  );

  // Flash image: 0x80,0x37 at address 0, a simple address hash elsewhere.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (a == 24'h0) return 8'h80;
    if (a == 24'h1) return 8'h37;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [15:0] exp_word(input logic [23:0] a);
`ifdef QSPI_ROM_BYTESWAP_EN
    return {fbyte(a + 24'd1), fbyte(a)};
`else
    return {fbyte(a), fbyte(a + 24'd1)};
`endif
  endfunction

`ifdef QSPI_ROM_BYTESWAP_EN
  localparam logic [15:0] SINGLE_EXP = 16'h3780;
`else
  localparam logic [15:0] SINGLE_EXP = 16'h8037;
`endif

  // Flash model: decodes header on rising SCLK, presents data nibble for the sampling edge.
  int          edge_k = 0;
  logic [7:0]  cap_cmd = 8'h0;
  logic [23:0] cap_addr = 24'h0;
  logic [7:0]  cap_mode = 8'hFF;
  always @(posedge qspi_clk or posedge qspi_cs_n) begin
    if (qspi_cs_n) edge_k = 0;
    else begin
      if (edge_k < 8)       cap_cmd  = {cap_cmd[6:0], qspi_dq_o[0]};
      else if (edge_k < 14) cap_addr = {cap_addr[19:0], qspi_dq_o};
      else if (edge_k < 16) cap_mode = {cap_mode[3:0], qspi_dq_o};
      if (edge_k >= 20) begin
        logic [7:0] b;
        b = fbyte(cap_addr + 24'((edge_k - 20) / 2));
        qspi_dq_i = ((edge_k - 20) % 2 == 0) ? b[7:4] : b[3:0];
      end
      edge_k++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Returns at the negedge right after the accepting edge.
  task automatic do_req(input logic [23:0] a, input logic [7:0] l);
    int w = 0;
    req_addr = a;
    req_len  = l;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout req_ready=%0b required=1", req_ready);
    end
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (qspi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got=%b want=1", qspi_cs_n); end
    checks++; if (qspi_clk !== 1'b0) begin errors++; $display("FAIL rst_sclk got=%b want=0", qspi_clk); end
    checks++; if (qspi_dq_oe !== 4'h0) begin errors++; $display("FAIL rst_oe got=%h want=0", qspi_dq_oe); end
    checks++; if (qspi_dq_o !== 4'h0) begin errors++; $display("FAIL rst_dq_o got=%h want=0", qspi_dq_o); end
    checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL rst_rd valid=%b last=%b want=0,0", rd_valid, rd_last); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data got=%h want=0000", rd_data); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_single_word;
    rd_ready = 1'b1;
    do_req(24'h000000, 8'd1);
    for (int c = 0; c <= 52; c++) begin
      if (c == 0) begin
        checks++; if (qspi_cs_n !== 1'b0 || qspi_clk !== 1'b0) begin errors++; $display("FAIL sw_start cs_n=%b sclk=%b want=0,0", qspi_cs_n, qspi_clk); end
        checks++; if (qspi_dq_oe !== 4'b0001 || qspi_dq_o[0] !== 1'b1) begin errors++; $display("FAIL sw_cmd_bit7 oe=%b dq0=%b want=0001,1", qspi_dq_oe, qspi_dq_o[0]); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_busy_ready got=%b want=0", req_ready); end
      end
      if (c == 1) begin
        checks++; if (qspi_clk !== 1'b1) begin errors++; $display("FAIL sw_high_phase sclk=%b want=1", qspi_clk); end
      end
      if (c == 16) begin
        checks++; if (qspi_dq_oe !== 4'b1111) begin errors++; $display("FAIL sw_addr_oe got=%b want=1111", qspi_dq_oe); end
      end
      if (c == 32 || c == 40) begin
        checks++; if (qspi_dq_oe !== 4'b0000) begin errors++; $display("FAIL sw_dummy_data_oe c=%0d got=%b want=0000", c, qspi_dq_oe); end
      end
      if (c == 47) begin
        checks++; if (rd_valid !== 1'b0 || qspi_cs_n !== 1'b0) begin errors++; $display("FAIL sw_early valid=%b cs_n=%b want=0,0", rd_valid, qspi_cs_n); end
      end
      if (c == 48) begin
        checks++; if (rd_valid !== 1'b1 || rd_last !== 1'b1) begin errors++; $display("FAIL sw_valid valid=%b last=%b want=1,1", rd_valid, rd_last); end
        checks++; if (rd_data !== SINGLE_EXP) begin errors++; $display("FAIL sw_data got=%h want=%h", rd_data, SINGLE_EXP); end
        checks++; if (qspi_cs_n !== 1'b1) begin errors++; $display("FAIL sw_cs_rise got=%b want=1", qspi_cs_n); end
      end
      if (c == 51) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_gap_ready got=%b want=0", req_ready); end
      end
      if (c == 52) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_idle_ready got=%b want=1", req_ready); end
      end
      @(negedge clk);
    end
    checks++; if (cap_cmd !== 8'hEB) begin errors++; $display("FAIL sw_cmd_decode got=%h want=eb", cap_cmd); end
    checks++; if (cap_addr !== 24'h0) begin errors++; $display("FAIL sw_addr_decode got=%h want=000000", cap_addr); end
    checks++; if (cap_mode !== 8'h00) begin errors++; $display("FAIL sw_mode_decode got=%h want=00", cap_mode); end
  endtask

  task automatic test_burst;
    logic [23:0] a = 24'h001000;
    int n = 0;
    rd_ready = 1'b1;
    do_req(a, 8'd4);
    for (int c = 0; c < 200 && n < 4; c++) begin
      if (rd_valid && rd_ready) begin
        checks++; if (rd_data !== exp_word(a + 24'(2 * n))) begin errors++; $display("FAIL burst_data w=%0d got=%h want=%h", n, rd_data, exp_word(a + 24'(2 * n))); end
        checks++; if (c != 48 + 8 * n) begin errors++; $display("FAIL burst_spacing w=%0d got=%0d want=%0d", n, c, 48 + 8 * n); end
        checks++; if (rd_last !== (n == 3)) begin errors++; $display("FAIL burst_last w=%0d got=%b want=%b", n, rd_last, n == 3); end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != 4) begin errors++; $display("FAIL burst_count got=%0d want=4", n); end
    checks++; if (cap_addr !== a) begin errors++; $display("FAIL burst_addr got=%h want=%h", cap_addr, a); end
  endtask

  task automatic test_backpressure;
    logic [23:0] a = 24'h001010;
    int n = 0;
    int clk_hi = 0;
    repeat (6) @(negedge clk);
    rd_ready = 1'b1;
    do_req(a, 8'd4);
    for (int c = 0; c < 400 && n < 4; c++) begin
      if (c == 48) rd_ready = 1'b0;
      if (c == 78) rd_ready = 1'b1;
      if (c >= 57 && c < 78 && qspi_clk) clk_hi++;
      if (c == 70) begin
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_word(a)) begin errors++; $display("FAIL bp_hold valid=%b data=%h want=1,%h", rd_valid, rd_data, exp_word(a)); end
      end
      if (rd_valid && rd_ready) begin
        checks++; if (rd_data !== exp_word(a + 24'(2 * n))) begin errors++; $display("FAIL bp_data w=%0d got=%h want=%h", n, rd_data, exp_word(a + 24'(2 * n))); end
        checks++; if (rd_last !== (n == 3)) begin errors++; $display("FAIL bp_last w=%0d got=%b want=%b", n, rd_last, n == 3); end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (clk_hi != 0) begin errors++; $display("FAIL bp_sclk_paused high_cycles=%0d want=0", clk_hi); end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", n); end
  endtask

  task automatic test_len_wrap_restart;
    logic [23:0] a = 24'h000200;
    int n = 0;
    int hi = 0;
    int w = 0;
    repeat (6) @(negedge clk);
    rd_ready = 1'b1;
    do_req(a, 8'd0);
    for (int c = 0; c < 2600; c++) begin
      if (rd_valid && rd_ready) begin
        checks++; if (rd_data !== exp_word(a + 24'(2 * n))) begin errors++; $display("FAIL wrap_data w=%0d got=%h want=%h", n, rd_data, exp_word(a + 24'(2 * n))); end
        checks++; if (rd_last !== (n == 255)) begin errors++; $display("FAIL wrap_last w=%0d got=%b want=%b", n, rd_last, n == 255); end
        n++;
      end
      if (n == 256) break;
      @(negedge clk);
    end
    checks++; if (n != 256) begin errors++; $display("FAIL wrap_count got=%0d want=256", n); end
    req_addr  = 24'h000000;
    req_len   = 8'd1;
    req_valid = 1'b1;
    while (qspi_cs_n && w < 50) begin hi++; @(negedge clk); w++; end
    req_valid = 1'b0;
    checks++; if (hi < 4 || w >= 50) begin errors++; $display("FAIL b2b_cs_high cycles=%0d want>=4 and restart", hi); end
    w = 0;
    while (!rd_valid && w < 100) begin @(negedge clk); w++; end
    checks++; if (rd_valid !== 1'b1 || rd_data !== SINGLE_EXP) begin errors++; $display("FAIL b2b_data valid=%b got=%h want=%h", rd_valid, rd_data, SINGLE_EXP); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int w = 0;
    rd_ready = 1'b1;
    do_req(24'h001000, 8'd4);
    for (int c = 0; c < 58; c++) begin
      if (c == 56) rd_ready = 1'b0;
      @(negedge clk);
    end
    checks++; if (qspi_cs_n !== 1'b0 || rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre cs_n=%b valid=%b want=0,1", qspi_cs_n, rd_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (qspi_cs_n !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_async cs_n=%b valid=%b want=1,0", qspi_cs_n, rd_valid); end
    checks++; if (qspi_dq_oe !== 4'h0 || qspi_clk !== 1'b0) begin errors++; $display("FAIL mid_async_pins oe=%h sclk=%b want=0,0", qspi_dq_oe, qspi_clk); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    do_req(24'h000000, 8'd1);
    while (!rd_valid && w < 100) begin @(negedge clk); w++; end
    checks++; if (rd_valid !== 1'b1 || rd_data !== SINGLE_EXP || rd_last !== 1'b1) begin errors++; $display("FAIL mid_recover valid=%b data=%h last=%b want=1,%h,1", rd_valid, rd_data, rd_last, SINGLE_EXP); end
    checks++; if (cap_addr !== 24'h0) begin errors++; $display("FAIL mid_recover_addr got=%h want=000000", cap_addr); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_len_wrap_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
